multisim_server_quasi_static_pull_mc: RTL
=========================================

MULTISIM_SERVER_QUASI_STATIC_PULL_MC -- requirements
Module: multisim_server_quasi_static_pull_mc

Interface
REQ-001 Parameter DATA_WIDTH, default 64, bit width of each channel's value.
REQ-002 Parameter N_CHANNELS, default 4, number of independent pull channels; legal range 1..64.
REQ-003 Parameter POLL_INTERVAL, default 1, clock cycles between successive poll slots; legal range >= 1.
REQ-004 Parameter RESET_VALUE, default '0, DATA_WIDTH value loaded into every channel output on reset.
REQ-005 clk  input  1  sole clock; all state updates on posedge clk.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 enable  input  1  polling enable; low freezes the poll counter and the channel pointer.
REQ-008 server_name  input  string[N_CHANNELS]  per-channel server name, passed unchanged to that channel's pull instance.
REQ-009 data  output  [N_CHANNELS][DATA_WIDTH]  held quasi-static value per channel.
REQ-010 data_valid  output  [N_CHANNELS]  sticky; set on the channel's first successful capture after reset.
REQ-011 data_changed  output  [N_CHANNELS]  one-cycle pulse on a capture that alters the held value.

Function
REQ-012 A poll-interval down-counter SHALL reload to POLL_INTERVAL-1 and decrement each cycle while enable=1.
REQ-013 A poll slot SHALL occur in the cycle where the counter equals 0 and enable=1; the counter SHALL reload in the following cycle.
REQ-014 A round-robin pointer SHALL select one channel per poll slot, starting at 0, advancing by 1 after every slot, and wrapping from N_CHANNELS-1 to 0.
REQ-015 During a poll slot, data_rdy SHALL be 1 for the selected channel only; all other channels SHALL see data_rdy=0.
REQ-016 Outside poll slots, or while enable=0, data_rdy SHALL be 0 for every channel.
REQ-017 Capture SHALL happen when data_vld and data_rdy are both 1 for the selected channel; the channel's data SHALL update on that posedge (latency 1 cycle from handshake).
REQ-018 If the selected channel's data_vld=0 in its slot, its data and data_valid SHALL be unchanged, and the pointer SHALL still advance.
REQ-019 data_changed[i] SHALL pulse for exactly the cycle after a capture on channel i when the captured value differs from the held value, or when data_valid[i] was 0.
REQ-020 A capture of a value equal to the held value on an already-valid channel SHALL NOT pulse data_changed.
REQ-021 At most one channel SHALL capture per cycle, so at most one data_changed bit is high in any cycle.
REQ-022 Deasserting enable SHALL hold the counter and pointer values; reasserting enable SHALL resume from the held values without skipping a channel.
REQ-023 With N_CHANNELS=1 and POLL_INTERVAL=1, data_rdy SHALL be constantly 1 while enabled, so the block captures every valid sample.

Reset
REQ-024 When rst_n=0, reset SHALL asynchronously force: data[i]=RESET_VALUE, data_valid=0, data_changed=0, pointer=0, counter=POLL_INTERVAL-1.
REQ-025 While in reset, data_rdy SHALL be 0 for all channels.
REQ-026 Reset asserted mid-handshake SHALL discard the in-flight sample without capturing it.
REQ-027 The first poll slot after reset deassertion SHALL occur POLL_INTERVAL cycles after the first enabled cycle.

Structure
REQ-028 A shared package multisim_quasi_static_pkg SHALL hold the channel-index width function (clog2 of N_CHANNELS, minimum 1) and the poll-counter width constant.
REQ-029 Each channel SHALL instantiate the existing multisim_server_pull sub-module (clk, server_name, data_rdy, data_vld, data) with DATA_WIDTH passed through.
REQ-030 No other new sub-module SHALL be introduced; the counter, pointer and capture logic are local.

Verification
REQ-031 N=4, PI=1, every server always valid with values 10/20/30/40 -> channels captured in order 0,1,2,3 on cycles 1-4 after reset; each data_changed pulses once; data_valid=4'hF after cycle 4.
REQ-032 N=2, PI=3, channel 0 always valid with value 5 -> data_rdy[0] high only every 6th cycle; data_changed[0] pulses only on the first capture.
REQ-033 Channel 1 has data_vld=0 in its slot -> data[1] stays RESET_VALUE, data_valid[1]=0, and the next slot selects channel 2.
REQ-034 enable dropped for 5 cycles while the pointer is at 2 -> no data_rdy during the gap; the first slot after re-enable selects channel 2.
REQ-035 rst_n pulsed low asynchronously (between clock edges) during a capture cycle -> all data return to RESET_VALUE immediately, data_valid=0, and the pointer restarts at 0.
REQ-036 N=1, PI=1, a value sequence 7,7,9 -> data tracks the sequence with 1-cycle latency; data_changed pulses for 7 (first capture) and 9 only.

Source files
------------

// File: rtl/multisim_quasi_static_pkg.sv
// Shared constants and helpers for the quasi-static multi-channel pull server.
// Channel-index width and poll-counter width live here so every user agrees on them.
package multisim_quasi_static_pkg;

    localparam int unsigned POLL_CNT_W = 32;

    // Channel-index width: clog2 of the channel count, never narrower than one bit.
    function automatic int unsigned ch_idx_w(input int unsigned n_channels);
        int unsigned w;
        if (n_channels > 32'd1) begin
            w = $clog2(n_channels);
        end else begin
            w = 32'd1;
        end
        return w;
    endfunction

endpackage

// File: rtl/multisim_server_pull.sv
// Pull-side endpoint of a named multisim server link: presents the server's current sample.
// The link itself is tied off here; in co-simulation the transport drives it by server name.
module multisim_server_pull #(
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  string                 server_name,
    input  logic                  data_rdy,
    output logic                  data_vld,
    output logic [DATA_WIDTH-1:0] data
);

    logic                  link_vld_s;
    logic [DATA_WIDTH-1:0] link_data_s;
    logic                  unused_s;

    assign link_vld_s  = 1'b0;
    assign link_data_s = '0;

    assign data_vld = link_vld_s;
    assign data     = link_data_s;

    // The pull request and name only matter to the transport, not to this endpoint.
    assign unused_s = ^{clk, data_rdy, (server_name.len() == 0)};

endmodule

// File: rtl/multisim_server_quasi_static_pull_mc.sv
// Multi-channel quasi-static puller: round-robins one poll slot per POLL_INTERVAL cycles
// across N_CHANNELS pull endpoints and holds the last captured value of each channel.
module multisim_server_quasi_static_pull_mc
    import multisim_quasi_static_pkg::*;
#(
    parameter int unsigned DATA_WIDTH              = 64,
    parameter int unsigned N_CHANNELS              = 4,
    parameter int unsigned POLL_INTERVAL           = 1,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE   = '0
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 enable,
    input  string                                server_name [N_CHANNELS],
    output logic [N_CHANNELS-1:0][DATA_WIDTH-1:0] data,
    output logic [N_CHANNELS-1:0]                data_valid,
    output logic [N_CHANNELS-1:0]                data_changed
);

    localparam int unsigned IDX_W = ch_idx_w(N_CHANNELS);
    localparam logic [POLL_CNT_W-1:0] CNT_RELOAD = POLL_CNT_W'(POLL_INTERVAL - 32'd1);
    localparam logic [IDX_W-1:0]      PTR_LAST   = IDX_W'(N_CHANNELS - 32'd1);

    logic [POLL_CNT_W-1:0] cnt_r;
    logic [IDX_W-1:0]      ptr_r;
    logic                  slot_s;
    logic [N_CHANNELS-1:0] data_rdy_s;
    logic [N_CHANNELS-1:0] pull_vld_s;
    logic [N_CHANNELS-1:0] cap_s;
    logic [DATA_WIDTH-1:0] pull_data_s [N_CHANNELS];

    // Poll-slot decode; rst_n gates it so nothing is offered while reset is held.
    always_comb begin
        slot_s     = 1'b0;
        data_rdy_s = '0;
        cap_s      = '0;
        if (rst_n && enable && (cnt_r == '0)) begin
            slot_s = 1'b1;
        end else begin
            slot_s = 1'b0;
        end
        for (int i = 0; i < int'(N_CHANNELS); i++) begin
            data_rdy_s[i] = slot_s && (ptr_r == IDX_W'(i));
            cap_s[i]      = data_rdy_s[i] && pull_vld_s[i];
        end
    end

    // Interval counter and round-robin pointer; both freeze while enable is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= CNT_RELOAD;
            ptr_r <= '0;
        end else if (slot_s) begin
            cnt_r <= CNT_RELOAD;
            ptr_r <= (ptr_r == PTR_LAST) ? '0 : ptr_r + IDX_W'(1);
        end else if (enable) begin
            cnt_r <= cnt_r - POLL_CNT_W'(1);
            ptr_r <= ptr_r;
        end else begin
            cnt_r <= cnt_r;
            ptr_r <= ptr_r;
        end
    end

    for (genvar i = 0; i < N_CHANNELS; i++) begin : g_ch
        logic [DATA_WIDTH-1:0] ch_data_r;
        logic                  ch_valid_r;
        logic                  ch_changed_r;

        multisim_server_pull #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_pull (
            .clk         (clk),
            .server_name (server_name[i]),
            .data_rdy    (data_rdy_s[i]),
            .data_vld    (pull_vld_s[i]),
            .data        (pull_data_s[i])
        );

        // Hold register: a first capture always counts as a change, later ones only if different.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ch_data_r    <= RESET_VALUE;
                ch_valid_r   <= 1'b0;
                ch_changed_r <= 1'b0;
            end else if (cap_s[i]) begin
                ch_data_r    <= pull_data_s[i];
                ch_valid_r   <= 1'b1;
                ch_changed_r <= !ch_valid_r || (pull_data_s[i] != ch_data_r);
            end else begin
                ch_data_r    <= ch_data_r;
                ch_valid_r   <= ch_valid_r;
                ch_changed_r <= 1'b0;
            end
        end

        assign data[i]         = ch_data_r;
        assign data_valid[i]   = ch_valid_r;
        assign data_changed[i] = ch_changed_r;
    end

endmodule
